// File: rtl/notch_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// notch_sweep_ctrl
//
// Steps a DDS tuning word across a notch filter and measures the
// peak-to-peak amplitude of the filter output at each point. Each point
// runs SETTLE (let the filter settle), then MEAS (track min/max of valid ADC
// samples), then REPORT (hold the result until the sink accepts it). Between
// points, STEP advances the tuning word. The sweep ends with a one-cycle DONE.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   start                  begin a sweep (accepted only while idle)
//   ftw_start, ftw_step    first tuning word and per-point increment
//   n_steps                number of sweep points (0 = immediate done)
//   settle_cyc, meas_cyc   settle / measurement clocks per point (0 acts as 1)
//   ftw                    tuning word to the DDS
//   adc_data, adc_valid    signed notch-output samples
//   res_data, res_idx      unsigned peak-to-peak result and its point index
//   res_valid, res_ready   result handshake
//   busy, done             not-idle flag, end-of-sweep pulse
// -----------------------------------------------------------------------------
module notch_sweep_ctrl #(
    parameter int FTW_W = 24,
    parameter int ADC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [FTW_W-1:0] ftw_start,
    input  logic [FTW_W-1:0] ftw_step,
    input  logic [7:0]       n_steps,
    input  logic [15:0]      settle_cyc,
    input  logic [15:0]      meas_cyc,
    output logic [FTW_W-1:0] ftw,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic [ADC_W-1:0] res_data,
    output logic [7:0]       res_idx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, SETTLE, MEAS, REPORT, STEP, DONE} state_t;

    localparam logic signed [ADC_W-1:0] ADC_POS_MAX = {1'b0, {(ADC_W-1){1'b1}}};
    localparam logic signed [ADC_W-1:0] ADC_NEG_MAX = {1'b1, {(ADC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [FTW_W-1:0]        ftw_q, ftw_d;
    logic [FTW_W-1:0]        step_q, step_d;
    logic [7:0]              idx_q, idx_d;
    logic [7:0]              n_q, n_d;
    logic [15:0]             settle_q, settle_d;
    logic [15:0]             meas_q, meas_d;
    logic [15:0]             cnt_q, cnt_d;
    logic signed [ADC_W-1:0] min_q, min_d;
    logic signed [ADC_W-1:0] max_q, max_d;
    logic                    seen_q, seen_d;
    logic [ADC_W-1:0]        res_data_q, res_data_d;
    logic [7:0]              res_idx_q, res_idx_d;

    logic signed [ADC_W-1:0] sample;
    logic signed [ADC_W-1:0] min_upd, max_upd;
    logic [ADC_W-1:0]        p2p;
    logic [15:0]             settle_len, meas_len;

    assign sample = adc_data;

    // Running extremes including the current clock's sample, so the last
    // MEAS clock still contributes to the reported result.
    assign min_upd = (adc_valid && (sample < min_q)) ? sample : min_q;
    assign max_upd = (adc_valid && (sample > max_q)) ? sample : max_q;

    // max >= min whenever a sample was seen, so the true difference lies in
    // 0..2^ADC_W-1 and the modulo-2^ADC_W subtraction is exact.
    assign p2p = max_upd - min_upd;

    // A programmed length of 0 still occupies one clock.
    assign settle_len = (settle_q == 16'd0) ? 16'd1 : settle_q;
    assign meas_len   = (meas_q == 16'd0) ? 16'd1 : meas_q;

    always_comb begin
        state_d    = state_q;
        ftw_d      = ftw_q;
        step_d     = step_q;
        idx_d      = idx_q;
        n_d        = n_q;
        settle_d   = settle_q;
        meas_d     = meas_q;
        cnt_d      = cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        seen_d     = seen_q;
        res_data_d = res_data_q;
        res_idx_d  = res_idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    step_d   = ftw_step;
                    n_d      = n_steps;
                    settle_d = settle_cyc;
                    meas_d   = meas_cyc;
                    idx_d    = 8'd0;
                    cnt_d    = 16'd0;
                    if (n_steps == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        ftw_d   = ftw_start;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == settle_len - 16'd1) begin
                    cnt_d   = 16'd0;
                    min_d   = ADC_POS_MAX;
                    max_d   = ADC_NEG_MAX;
                    seen_d  = 1'b0;
                    state_d = MEAS;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            MEAS: begin
                min_d  = min_upd;
                max_d  = max_upd;
                seen_d = seen_q | adc_valid;
                if (cnt_q == meas_len - 16'd1) begin
                    cnt_d      = 16'd0;
                    res_idx_d  = idx_q;
                    res_data_d = (seen_q || adc_valid) ? p2p : '0;
                    state_d    = REPORT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = (idx_q == n_q - 8'd1) ? DONE : STEP;
                end
            end
            STEP: begin
                ftw_d   = ftw_q + step_q;
                idx_d   = idx_q + 8'd1;
                cnt_d   = 16'd0;
                state_d = SETTLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ftw_q      <= '0;
            step_q     <= '0;
            idx_q      <= 8'd0;
            n_q        <= 8'd0;
            settle_q   <= 16'd0;
            meas_q     <= 16'd0;
            cnt_q      <= 16'd0;
            min_q      <= '0;
            max_q      <= '0;
            seen_q     <= 1'b0;
            res_data_q <= '0;
            res_idx_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            ftw_q      <= ftw_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            settle_q   <= settle_d;
            meas_q     <= meas_d;
            cnt_q      <= cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
            seen_q     <= seen_d;
            res_data_q <= res_data_d;
            res_idx_q  <= res_idx_d;
        end
    end

    assign ftw       = ftw_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign res_valid = (state_q == REPORT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
